// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg
// Shared constants for the program loader: FSM state encodings, the HALT
// sentinel word, the default instruction memory depth and the register
// clear value.
package instruction_loader_pkg;

    localparam int BITS_FOR_STATE_COUNTER_LOADER = 3;

    localparam logic [BITS_FOR_STATE_COUNTER_LOADER-1:0] STATE_LOADER_IDLE  = 3'd0;
    localparam logic [BITS_FOR_STATE_COUNTER_LOADER-1:0] STATE_LOADER_RECV  = 3'd1;
    localparam logic [BITS_FOR_STATE_COUNTER_LOADER-1:0] STATE_LOADER_WRITE = 3'd2;
    localparam logic [BITS_FOR_STATE_COUNTER_LOADER-1:0] STATE_LOADER_DONE  = 3'd3;
    localparam logic [BITS_FOR_STATE_COUNTER_LOADER-1:0] STATE_LOADER_ERROR = 3'd4;

    // The program image ends with this word; it is written like any other word.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam int DEFAULT_MEM_DEPTH_WORDS = 256;

    // Register clear value shared by all loader registers.
    localparam logic CLEAR = 1'b0;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// instruction_loader_word_assembler
// Packs accepted stream bytes into a 32-bit big-endian word (first byte ends
// up in the MSBs) and flags the acceptance of the 4th byte.
// Ports:
//   i_clk            clock
//   i_reset          asynchronous active-low reset
//   i_clear          synchronous clear of byte counter and shift register
//   i_byte_accept    byte on i_byte is consumed this cycle
//   i_byte           stream byte
//   o_word           assembled word (valid the cycle after word_complete)
//   o_word_complete  the byte accepted this cycle completes a word
module instruction_loader_word_assembler
    import instruction_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_byte_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_complete
);

    logic [1:0]  byte_idx;
    logic [31:0] shift;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_idx <= {2{CLEAR}};
            shift    <= {32{CLEAR}};
        end else if (i_clear) begin
            byte_idx <= {2{CLEAR}};
            shift    <= {32{CLEAR}};
        end else if (i_byte_accept) begin
            shift    <= {shift[23:0], i_byte};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Only feeds the FSM next-state logic, never a top-level output.
    assign o_word_complete = i_byte_accept && (byte_idx == 2'd3);
    assign o_word          = shift;

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader
// Writer side of the instruction memory: receives a byte stream, packs it into
// big-endian words and writes them at byte addresses 0, 4, 8, ... while holding
// the PC in clear. The load ends on the HALT word (done) or when the last
// memory word has been written without seeing HALT (error).
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_start          level-sampled start (IDLE/DONE/ERROR only)
//   i_byte_valid     i_byte carries a valid byte
//   i_byte           stream byte
//   o_byte_ready     a byte can be accepted this cycle
//   o_wr_en          one-cycle memory write strobe
//   o_wr_addr        word-aligned byte address of the write
//   o_wr_data        word being written
//   o_cpu_clear      PC clear, high while loading and in ERROR
//   o_done           load finished on HALT
//   o_error          memory filled before HALT
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int PC_SIZE          = 32,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int MEM_DEPTH_WORDS  = DEFAULT_MEM_DEPTH_WORDS
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_byte_valid,
    input  logic [7:0]                  i_byte,
    output logic                        o_byte_ready,
    output logic                        o_wr_en,
    output logic [PC_SIZE-1:0]          o_wr_addr,
    output logic [INSTRUCTION_SIZE-1:0] o_wr_data,
    output logic                        o_cpu_clear,
    output logic                        o_done,
    output logic                        o_error
);

    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH_WORDS - 1);

    logic [BITS_FOR_STATE_COUNTER_LOADER-1:0] state, state_next;
    logic [IDX_W-1:0] word_idx, word_idx_next;
    logic             asm_clear;
    logic             byte_accept;
    logic             word_complete;
    logic [31:0]      word;
    logic             in_write;

    assign byte_accept = i_byte_valid && (state == STATE_LOADER_RECV);

    instruction_loader_word_assembler u_word_assembler (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clear         (asm_clear),
        .i_byte_accept   (byte_accept),
        .i_byte          (i_byte),
        .o_word          (word),
        .o_word_complete (word_complete)
    );

    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        asm_clear     = 1'b0;
        case (state)
            STATE_LOADER_IDLE, STATE_LOADER_DONE, STATE_LOADER_ERROR: begin
                if (i_start) begin
                    state_next    = STATE_LOADER_RECV;
                    word_idx_next = '0;
                    asm_clear     = 1'b1;
                end
            end
            STATE_LOADER_RECV: begin
                if (word_complete) state_next = STATE_LOADER_WRITE;
            end
            STATE_LOADER_WRITE: begin
                if (word == HALT_WORD) begin
                    state_next = STATE_LOADER_DONE;
                end else if (word_idx == LAST_IDX) begin
                    // Index stays saturated so the address never wraps.
                    state_next = STATE_LOADER_ERROR;
                end else begin
                    word_idx_next = word_idx + 1'b1;
                    state_next    = STATE_LOADER_RECV;
                end
            end
            default: state_next = STATE_LOADER_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= STATE_LOADER_IDLE;
            word_idx <= {IDX_W{CLEAR}};
        end else begin
            state    <= state_next;
            word_idx <= word_idx_next;
        end
    end

    // All outputs decode registered state only.
    assign in_write     = (state == STATE_LOADER_WRITE);
    assign o_byte_ready = (state == STATE_LOADER_RECV);
    assign o_wr_en      = in_write;
    assign o_wr_addr    = in_write ? (PC_SIZE'(word_idx) << 2) : '0;
    assign o_wr_data    = in_write ? INSTRUCTION_SIZE'(word) : '0;
    assign o_cpu_clear  = (state == STATE_LOADER_RECV) || in_write
                          || (state == STATE_LOADER_ERROR);
    assign o_done       = (state == STATE_LOADER_DONE);
    assign o_error      = (state == STATE_LOADER_ERROR);

endmodule
